// File: rtl/jtkcpu_muldiv.sv
// Sequential multiply/divide unit: restoring division (one quotient bit per
// enabled clock) and shift-add multiplication, with a final sign-fix step.
module jtkcpu_muldiv #(
    parameter int DW = 16,
    parameter int SW = 8
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             cen,
    input  logic             start,
    input  logic             mode,
    input  logic             sign,
    input  logic [DW-1:0]    op0,
    input  logic [SW-1:0]    op1,
    output logic [DW-1:0]    quot,
    output logic [SW-1:0]    rem,
    output logic [DW+SW-1:0] prod,
    output logic             busy,
    output logic             done,
    output logic             v,
    output logic             dz
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [5:0] DW_M1 = 6'(DW - 1);
    localparam logic [5:0] SW_M1 = 6'(SW - 1);

    state_t          r_state, w_state_next;
    logic            r_mode, r_neg_q, r_neg_r, r_dz, r_v;
    logic [DW-1:0]   r_a;     // dividend magnitude / quotient, or multiplicand magnitude
    logic [SW-1:0]   r_b;     // divisor magnitude, or multiplier / low product bits
    logic [SW-1:0]   r_part;  // partial remainder
    logic [DW-1:0]   r_hi;    // high product bits
    logic [5:0]      r_cnt;

    logic            w_op0_neg, w_op1_neg, w_start_dz, w_start_v;
    logic [DW-1:0]   w_op0_mag;
    logic [SW-1:0]   w_op1_mag;
    logic [SW:0]     w_trial, w_diff;
    logic            w_qbit;
    logic [SW-1:0]   w_part_next;
    logic [DW:0]     w_sum;

    assign w_op0_neg  = sign & op0[DW-1];
    assign w_op1_neg  = sign & op1[SW-1];
    assign w_op0_mag  = w_op0_neg ? -op0 : op0;
    assign w_op1_mag  = w_op1_neg ? -op1 : op1;
    assign w_start_dz = ~mode & (op1 == '0);
    assign w_start_v  = ~mode & sign & (op0 == {1'b1, {(DW-1){1'b0}}}) & (&op1);

    // Borrow out of the (SW+1)-bit subtraction means the trial value is below the divisor.
    assign w_trial     = {r_part, r_a[DW-1]};
    assign w_diff      = w_trial - {1'b0, r_b};
    assign w_qbit      = ~w_diff[SW];
    assign w_part_next = w_qbit ? w_diff[SW-1:0] : w_trial[SW-1:0];

    assign w_sum = {1'b0, r_hi} + (r_b[0] ? {1'b0, r_a} : {(DW+1){1'b0}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else if (cen)
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = (w_start_dz | w_start_v) ? FIX : RUN;
            RUN:     if (r_cnt == 6'd0) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_v     <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_hi    <= '0;
            r_cnt   <= '0;
            quot    <= '0;
            rem     <= '0;
            prod    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            v       <= 1'b0;
            dz      <= 1'b0;
        end else if (cen) begin
            done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_mode  <= mode;
                    r_neg_q <= w_op0_neg ^ w_op1_neg;
                    r_neg_r <= w_op0_neg;
                    r_dz    <= w_start_dz;
                    r_v     <= w_start_v & ~w_start_dz;
                    // Exceptional divides report the raw dividend, so keep it unmodified.
                    r_a     <= (w_start_dz | w_start_v) ? op0 : w_op0_mag;
                    r_b     <= w_op1_mag;
                    r_part  <= '0;
                    r_hi    <= '0;
                    r_cnt   <= mode ? SW_M1 : DW_M1;
                    busy    <= 1'b1;
                    v       <= 1'b0;
                    dz      <= 1'b0;
                end
                RUN: begin
                    r_cnt <= r_cnt - 6'd1;
                    if (r_mode) begin
                        r_hi <= w_sum[DW:1];
                        r_b  <= {w_sum[0], r_b[SW-1:1]};
                    end else begin
                        r_part <= w_part_next;
                        r_a    <= {r_a[DW-2:0], w_qbit};
                    end
                end
                FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (r_dz) begin
                        dz   <= 1'b1;
                        quot <= '1;
                        rem  <= r_a[SW-1:0];
                    end else if (r_v) begin
                        v    <= 1'b1;
                        quot <= r_a;
                        rem  <= '0;
                    end else if (r_mode) begin
                        prod <= r_neg_q ? -{r_hi, r_b} : {r_hi, r_b};
                    end else begin
                        quot <= r_neg_q ? -r_a : r_a;
                        rem  <= r_neg_r ? -r_part : r_part;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
